// File: rtl/softplus_vector_sequencer.sv
// Sequences a shared softplus unit over a source buffer and writes results to a destination buffer.
// Optional cycle counter output cyc_cnt is enabled by defining SPSEQ_PERF_CNT_EN.
module softplus_vector_sequencer #(
    parameter int unsigned N      = 16,
    parameter int unsigned AW     = 8,
    parameter int unsigned LW     = 9,
    parameter int unsigned SP_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SPSEQ_PERF_CNT_EN
    output logic [31:0]   cyc_cnt,
`endif
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_src,
    input  logic [AW-1:0] cmd_dst,
    input  logic [LW-1:0] cmd_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [N-1:0]  rd_data,
    output logic          sp_start,
    output logic [N-1:0]  sp_x,
    input  logic [N-1:0]  sp_y,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
);

    localparam int unsigned CW = $clog2(SP_LAT + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StWait, StWrite, StFin
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, dst_q;
    logic [LW-1:0] len_q, idx_q;
    logic [CW-1:0] wait_q;
    logic [N-1:0]  sp_x_q, wr_data_q;
    logic          accept;
    logic          wait_last;

    assign accept    = (state_q == StIdle) && cmd_valid && !abort;
    assign wait_last = (wait_q == CW'(SP_LAT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (cmd_len == '0) ? StFin : StFetch;
            StFetch: state_d = StLoad;
            StLoad:  state_d = StWait;
            StWait:  if (wait_last) state_d = StWrite;
            StWrite: state_d = (idx_q + LW'(1) == len_q) ? StFin : StFetch;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort pre-empts every busy state; in IDLE it only blocks acceptance.
        if (abort && state_q != StIdle) state_d = StIdle;
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StFin) && !abort;
        rd_en     = (state_q == StFetch);
        sp_start  = (state_q == StLoad);
        wr_en     = (state_q == StWrite) && !abort;
        rd_addr   = src_q + AW'(idx_q);
        wr_addr   = dst_q + AW'(idx_q);
        sp_x      = sp_x_q;
        wr_data   = wr_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            sp_x_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q <= cmd_src;
                dst_q <= cmd_dst;
                len_q <= cmd_len;
                idx_q <= '0;
            end
            if (state_q == StLoad) begin
                sp_x_q <= rd_data;
                wait_q <= '0;
            end
            if (state_q == StWait) begin
                wait_q <= wait_q + CW'(1);
                if (wait_last) wr_data_q <= sp_y;
            end
            if (state_q == StWrite && !abort) idx_q <= idx_q + LW'(1);
        end
    end

`ifdef SPSEQ_PERF_CNT_EN
    // Cleared on accept, counts busy cycles, naturally frozen once back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (accept) begin
            cyc_cnt <= '0;
        end else if (state_q != StIdle) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule
